// File: rtl/prog_loader.sv
// prog_loader: streams multi-segment images (ADDR, LEN, data, CSUM) into memory,
// then loads the PC with the entry address and enables the core.
module prog_loader #(
    parameter int WORD_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int MAX_SEGS = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_value,
    output logic              cpu_run,
    output logic              busy,
    output logic [1:0]        err,
    output logic [2:0]        seg_count,
    output logic [CNT_W-1:0]  words_loaded
);
    typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CSUM, DONE, ERROR} state_t;
    state_t            state;
    logic [ADDR_W-1:0] cur_addr, last_addr;
    logic [WORD_W-1:0] last_data, sum;
    logic [CNT_W-1:0]  remaining;
    logic              acc;
    assign in_ready  = (state == ADDR) | (state == LEN) | (state == CSUM) | ((state == DATA) & mem_ready);
    assign acc       = in_valid & in_ready;
    assign mem_we    = (state == DATA) & acc;
    // memory port holds the last written address/data once out of DATA
    assign mem_addr  = (state == DATA) ? cur_addr : last_addr;
    assign mem_wdata = (state == DATA) ? in_data : last_data;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cur_addr     <= '0;
            last_addr    <= '0;
            last_data    <= '0;
            sum          <= '0;
            remaining    <= '0;
            pc_load      <= 1'b0;
            pc_value     <= '0;
            cpu_run      <= 1'b0;
            busy         <= 1'b0;
            err          <= 2'd0;
            seg_count    <= 3'd0;
            words_loaded <= '0;
        end else begin
            pc_load <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: if (start) begin
                    state        <= ADDR;
                    seg_count    <= 3'd0;
                    words_loaded <= '0;
                    err          <= 2'd0;
                    cpu_run      <= 1'b0;
                    busy         <= 1'b1;
                end
                ADDR: if (acc) begin
                    cur_addr <= in_data[ADDR_W-1:0];
                    state    <= LEN;
                end
                LEN: if (acc) begin
                    if (in_data == '0) begin
                        pc_value <= cur_addr;
                        pc_load  <= 1'b1;
                        cpu_run  <= 1'b1;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end else if (32'(seg_count) == MAX_SEGS) begin
                        err   <= 2'd2;
                        busy  <= 1'b0;
                        state <= ERROR;
                    end else begin
                        remaining <= CNT_W'(in_data);
                        sum       <= '0;
                        state     <= DATA;
                    end
                end
                DATA: if (acc) begin
                    cur_addr     <= cur_addr + ADDR_W'(1);
                    sum          <= sum + in_data;
                    remaining    <= remaining - CNT_W'(1);
                    words_loaded <= words_loaded + CNT_W'(1);
                    last_addr    <= cur_addr;
                    last_data    <= in_data;
                    if (remaining == CNT_W'(1)) state <= CSUM;
                end
                CSUM: if (acc) begin
                    if (in_data == sum) begin
                        seg_count <= (seg_count == 3'd7) ? 3'd7 : seg_count + 3'd1;
                        state     <= ADDR;
                    end else begin
                        err   <= 2'd1;
                        busy  <= 1'b0;
                        state <= ERROR;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized image loads checked every cycle against a
// parsed-image reference model, plus directed images with literal expectations.
module tb_prog_loader;
    localparam int MS = 2;
    logic        clk = 0, rst_n = 0, start = 0, in_valid = 0, mem_ready = 0;
    logic [15:0] in_data = 0;
    logic        in_ready, mem_we, pc_load, cpu_run, busy;
    logic [15:0] mem_addr, mem_wdata, pc_value, words_loaded;
    logic [1:0]  err;
    logic [2:0]  seg_count;

    prog_loader #(.WORD_W(16), .ADDR_W(16), .MAX_SEGS(MS), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .pc_load(pc_load), .pc_value(pc_value), .cpu_run(cpu_run),
        .busy(busy), .err(err), .seg_count(seg_count), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0, fails = 0;
    logic [15:0] img[$];
    int          kind[$], segs_b[$], words_b[$];
    logic [15:0] waddr[$];
    int          end_idx, outcome, fin_segs, fin_words;
    logic [15:0] pc;
    logic [15:0] hold_addr = 0, hold_data = 0, pc_hold = 0;
    int          last_err = 0, last_segs = 0, last_words = 0;
    bit          last_run = 0, pc_pulse = 0;
    logic [15:0] mem [0:65535];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Walk the image word by word, recording per word what it is and the counters before it.
    function automatic void parse();
        int i = 0, segs = 0, words = 0, len;
        logic [15:0] a, s;
        kind.delete(); segs_b.delete(); words_b.delete(); waddr.delete();
        while (1) begin
            a = img[i];
            kind.push_back(0); waddr.push_back(0); segs_b.push_back(segs); words_b.push_back(words);
            i++;
            len = int'(img[i]);
            kind.push_back(0); waddr.push_back(0); segs_b.push_back(segs); words_b.push_back(words);
            if (len == 0) begin end_idx = i; outcome = 0; pc = a; break; end
            if (segs == MS) begin end_idx = i; outcome = 2; break; end
            i++;
            s = 0;
            for (int j = 0; j < len; j++) begin
                kind.push_back(1); waddr.push_back(a); segs_b.push_back(segs); words_b.push_back(words);
                s += img[i]; a++; words++; i++;
            end
            kind.push_back(0); waddr.push_back(0); segs_b.push_back(segs); words_b.push_back(words);
            if (img[i] != s) begin end_idx = i; outcome = 1; break; end
            segs = (segs < 7) ? segs + 1 : 7;
            i++;
        end
        fin_segs = segs;
        fin_words = words;
    endfunction

    task automatic add_seg(logic [15:0] a, int len, bit bad);
        logic [15:0] s = 0, d;
        img.push_back(a);
        img.push_back(16'(len));
        for (int j = 0; j < len; j++) begin
            d = 16'($urandom);
            img.push_back(d);
            s += d;
        end
        img.push_back(bad ? s + 16'd1 : s);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_pc_load"}, pc_load, 0);
        chk({tag, "_pc_value"}, pc_value, 0);
        chk({tag, "_cpu_run"}, cpu_run, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_seg_count"}, seg_count, 0);
        chk({tag, "_words"}, words_loaded, 0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1 chk_zero("rst_async");
        @(posedge clk);
        #1 chk_zero("rst_hold");
        @(negedge clk);
        rst_n = 1; start = 0; in_valid = 0;
        hold_addr = 0; hold_data = 0; pc_hold = 0;
        last_err = 0; last_segs = 0; last_words = 0; last_run = 0; pc_pulse = 0;
    endtask

    // One cycle outside a load: junk on the stream must be refused.
    task automatic check_idle(bit st);
        @(negedge clk);
        start = st; in_valid = 1'($urandom); in_data = 16'($urandom); mem_ready = 1'($urandom);
        #1;
        chk("idle_in_ready", in_ready, 0);
        chk("idle_mem_we", mem_we, 0);
        chk("idle_mem_addr", mem_addr, hold_addr);
        chk("idle_mem_wdata", mem_wdata, hold_data);
        chk("idle_busy", busy, 0);
        chk("idle_cpu_run", cpu_run, last_run);
        chk("idle_err", err, last_err);
        chk("idle_pc_load", pc_load, pc_pulse);
        chk("idle_pc_value", pc_value, pc_hold);
        chk("idle_seg_count", seg_count, last_segs);
        chk("idle_words", words_loaded, last_words);
        @(posedge clk);
        pc_pulse = 0;
    endtask

    task automatic run_load(bit toggle, int reset_after);
        int n = 0, cyc = 0;
        bit ended = 0, acc, rdy;
        parse();
        check_idle(1);
        while (!ended) begin
            @(negedge clk);
            start     = ($urandom_range(0, 7) == 0);
            in_valid  = toggle ? 1'b1 : ($urandom_range(0, 3) != 0);
            in_data   = in_valid ? img[n] : 16'($urandom);
            mem_ready = toggle ? 1'(cyc % 2) : ($urandom_range(0, 3) != 0);
            #1;
            if (n == reset_after) begin
                do_reset();
                return;
            end
            rdy = (kind[n] == 1) ? mem_ready : 1'b1;
            chk("in_ready", in_ready, rdy);
            chk("busy", busy, 1);
            chk("cpu_run", cpu_run, 0);
            chk("err", err, 0);
            chk("pc_load", pc_load, 0);
            chk("pc_value", pc_value, pc_hold);
            chk("seg_count", seg_count, segs_b[n]);
            chk("words_loaded", words_loaded, words_b[n]);
            chk("mem_we", mem_we, (kind[n] == 1) && in_valid && mem_ready);
            chk("mem_addr", mem_addr, (kind[n] == 1) ? waddr[n] : hold_addr);
            chk("mem_wdata", mem_wdata, (kind[n] == 1) ? in_data : hold_data);
            if (mem_we) mem[mem_addr] = mem_wdata;
            acc = in_valid && rdy;
            @(posedge clk);
            if (acc) begin
                if (kind[n] == 1) begin hold_addr = waddr[n]; hold_data = img[n]; end
                if (n == end_idx) ended = 1;
                n++;
            end
            cyc++;
            if (cyc > 2000) begin
                checks++; fails++;
                $display("FAIL load_timeout: accepted %0d words, needed %0d", n, end_idx + 1);
                return;
            end
        end
        start = 0;
        last_err = outcome; last_segs = fin_segs; last_words = fin_words; last_run = (outcome == 0);
        if (outcome == 0) pc_hold = pc;
        pc_pulse = (outcome == 0);
        repeat (3) check_idle(0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 0;
        #12 chk_zero("reset");
        @(negedge clk) rst_n = 1;

        img = '{16'h3000, 16'd3, 16'h1111, 16'h2222, 16'h3333, 16'h6666, 16'h3000, 16'h0000};
        run_load(0, -1);
        chk("model_pc", pc, 16'h3000);
        @(negedge clk); #1;
        chk("lit_pc_value", pc_value, 16'h3000);
        chk("lit_cpu_run", cpu_run, 1);
        chk("lit_seg_count", seg_count, 1);
        chk("lit_words", words_loaded, 3);
        chk("lit_mem3000", mem[16'h3000], 16'h1111);
        chk("lit_mem3001", mem[16'h3001], 16'h2222);
        chk("lit_mem3002", mem[16'h3002], 16'h3333);

        for (int i = 0; i < 3; i++) mem[16'h3000 + i] = 0;
        img = '{16'h3000, 16'd3, 16'h1111, 16'h2222, 16'h3333, 16'h6665, 16'h3000, 16'h0000};
        run_load(0, -1);
        chk("model_csum_outcome", outcome, 1);
        @(negedge clk); #1;
        chk("lit_csum_err", err, 1);
        chk("lit_csum_run", cpu_run, 0);
        chk("lit_csum_words", words_loaded, 3);
        chk("lit_csum_mem3002", mem[16'h3002], 16'h3333);

        img = '{16'h4000, 16'd4, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h000A, 16'h4000, 16'h0000};
        run_load(1, -1);
        @(negedge clk); #1;
        chk("lit_bp_err", err, 0);
        chk("lit_bp_words", words_loaded, 4);
        chk("lit_bp_mem4003", mem[16'h4003], 16'h0004);

        img = '{16'hFFFE, 16'd3, 16'h0101, 16'h0202, 16'h0303, 16'h0606, 16'h0000, 16'h0000};
        run_load(0, -1);
        chk("lit_wrap_fffe", mem[16'hFFFE], 16'h0101);
        chk("lit_wrap_ffff", mem[16'hFFFF], 16'h0202);
        chk("lit_wrap_0000", mem[16'h0000], 16'h0303);

        img = '{16'h1000, 16'd1, 16'h0005, 16'h0005, 16'h2000, 16'd1, 16'h0007, 16'h0007,
                16'h5000, 16'd2, 16'h0009, 16'h000A, 16'h0013, 16'h7000, 16'h0000};
        run_load(0, -1);
        @(negedge clk); #1;
        chk("lit_lim_err", err, 2);
        chk("lit_lim_segs", seg_count, 2);
        chk("lit_lim_words", words_loaded, 2);
        chk("lit_lim_mem5000", mem[16'h5000], 16'h0000);

        img = '{16'h6000, 16'd5, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h000F, 16'h6000, 16'h0000};
        run_load(0, 4);
        chk("lit_rst_mem6001", mem[16'h6001], 16'h0002);
        chk("lit_rst_mem6002", mem[16'h6002], 16'h0000);
        run_load(0, -1);
        @(negedge clk); #1;
        chk("lit_reload_words", words_loaded, 5);
        chk("lit_reload_run", cpu_run, 1);

        repeat (30) begin
            img.delete();
            repeat ($urandom_range(0, 3))
                add_seg(($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom),
                        $urandom_range(1, 5), $urandom_range(0, 7) == 0);
            img.push_back(16'($urandom));
            img.push_back(16'h0000);
            run_load($urandom_range(0, 4) == 0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
